// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time framed byte stream loader for the instruction memory
module imem_loader #(
  parameter int MEM_BYTES   = 256,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int          IDLE_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MEM_LIM = 17'(MEM_BYTES);
  localparam logic [7:0]  SYNC    = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_WRITE, S_CHKSUM, S_DONE, S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        len_q;
  logic [15:0]        byte_cnt_q;
  logic [7:0]         sum_q;
  logic [31:0]        wbuf_q;
  logic [3:0]         be_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic [IDLE_W-1:0]  idle_q;
  logic               hold_q, done_q, err_q;

  logic        hs;
  logic        counting;
  logic        timeout;
  logic        last_byte;
  logic [15:0] len_full;
  logic [1:0]  lane;

  assign hs        = rx_valid && rx_ready;
  assign lane      = byte_cnt_q[1:0];
  assign len_full  = {rx_data, len_q[7:0]};
  assign last_byte = (byte_cnt_q + 16'd1) == len_q;
  assign counting  = state_q inside {S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_CHKSUM};
  assign timeout   = counting && !hs && (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: frame parsing, word flush points and timeout abort
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (hs && rx_data == SYNC) state_d = S_LEN_LO;
      S_LEN_LO:  if (hs) state_d = S_LEN_HI;
                 else if (timeout) state_d = S_ERROR;
      S_LEN_HI: begin
        if (hs) begin
          if ({1'b0, len_full} > MEM_LIM) state_d = S_ERROR;
          else if (len_full == 16'd0)     state_d = S_CHKSUM;
          else                            state_d = S_PAYLOAD;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_PAYLOAD: if (hs) begin
                   if (lane == 2'd3 || last_byte) state_d = S_WRITE;
                 end else if (timeout) state_d = S_ERROR;
      S_WRITE:   state_d = (byte_cnt_q == len_q) ? S_CHKSUM : S_PAYLOAD;
      S_CHKSUM:  if (hs) state_d = (rx_data == sum_q) ? S_DONE : S_ERROR;
                 else if (timeout) state_d = S_ERROR;
      S_DONE:    state_d = S_IDLE;
      S_ERROR:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath: length latch, word assembly, checksum, idle counter and sticky status
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= '0;
      byte_cnt_q <= '0;
      sum_q      <= '0;
      wbuf_q     <= '0;
      be_q       <= '0;
      waddr_q    <= '0;
      idle_q     <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      idle_q <= (counting && !hs) ? idle_q + IDLE_W'(1) : '0;
      case (state_q)
        S_IDLE: if (hs && rx_data == SYNC) begin
          done_q     <= 1'b0;
          err_q      <= 1'b0;
          byte_cnt_q <= '0;
          sum_q      <= '0;
          wbuf_q     <= '0;
          be_q       <= '0;
          hold_q     <= 1'b1;
        end
        S_LEN_LO: if (hs) len_q[7:0]  <= rx_data;
        S_LEN_HI: if (hs) len_q[15:8] <= rx_data;
        S_PAYLOAD: if (hs) begin
          wbuf_q[{lane, 3'b000} +: 8] <= rx_data;
          be_q[lane]                  <= 1'b1;
          sum_q                       <= sum_q + rx_data;
          byte_cnt_q                  <= byte_cnt_q + 16'd1;
          waddr_q                     <= {byte_cnt_q[ADDR_W-1:2], 2'b00};
        end
        S_WRITE: begin
          wbuf_q <= '0;
          be_q   <= '0;
        end
        default: ;
      endcase
      if (state_d == S_DONE) begin
        done_q <= 1'b1;
        hold_q <= 1'b0;
      end
      if (state_d == S_ERROR) err_q <= 1'b1;
    end
  end

  // Outputs: handshake readiness, write port driven only in the WRITE cycle, status flags
  always_comb begin
    rx_ready  = !reset && (state_q inside {S_IDLE, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_CHKSUM});
    mem_we    = (state_q == S_WRITE);
    mem_addr  = mem_we ? waddr_q : '0;
    mem_wdata = mem_we ? wbuf_q  : '0;
    mem_be    = mem_we ? be_q    : '0;
    cpu_hold  = hold_q;
    load_done = done_q;
    load_err  = err_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  imem_loader #(.MEM_BYTES(256), .ADDR_W(8), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // expected writes: {addr[7:0], wdata[31:0], be[3:0]}
  logic [43:0] exp_q[$];
  logic [43:0] mon_e;

  typedef struct {
    logic [127:0] v;
    int           n;
    bit           done;
    bit           err;
    bit           gaps;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // write monitor: every strobe must match the next scoreboard entry
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h be %b, expected no write",
                 mem_addr, mem_wdata, mem_be);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", {24'd0, mem_addr}, {24'd0, mon_e[43:36]});
        chk("write_data", mem_wdata, mon_e[35:4]);
        chk("write_be", {28'd0, mem_be}, {28'd0, mon_e[3:0]});
      end
    end
  end

  function automatic logic [7:0] bt(input logic [127:0] v, input int n, input int i);
    return v[(n-1-i)*8 +: 8];
  endfunction

  // reference model: find sync, read length, push the expected word writes
  task automatic model(input logic [127:0] v, input int n);
    int s;
    int len;
    int k;
    logic [31:0] w;
    logic [3:0]  be;
    s = -1;
    for (int i = 0; i < n; i++) if (s < 0 && bt(v, n, i) == 8'hA5) s = i;
    if (s < 0 || s + 2 >= n) return;
    len = int'(bt(v, n, s+1)) | (int'(bt(v, n, s+2)) << 8);
    if (len > 256) return;
    w = '0;
    be = '0;
    for (int i = 0; i < len; i++) begin
      k = i % 4;
      w[8*k +: 8] = bt(v, n, s+3+i);
      be[k] = 1'b1;
      if (k == 3 || i == len - 1) begin
        exp_q.push_back({8'(i & ~3), w, be});
        w = '0;
        be = '0;
      end
    end
  endtask

  // drive one byte at a negedge and hold it until accepted
  task automatic send(input logic [7:0] b, input int maxgap);
    int g;
    bit ok;
    g = $urandom_range(maxgap, 0);
    rx_valid = 1'b0;
    repeat (g) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      ok = rx_ready;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: byte 0x%0h not accepted within 50 cycles", b);
    end
  endtask

  task automatic run_frame(input vec_t t, input string name);
    model(t.v, t.n);
    for (int i = 0; i < t.n; i++) send(bt(t.v, t.n, i), t.gaps ? 5 : 0);
    repeat (4) @(negedge clk);
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_done"}, {31'd0, load_done}, {31'd0, t.done});
    chk({name, "_err"}, {31'd0, load_err}, {31'd0, t.err});
    chk({name, "_hold"}, {31'd0, cpu_hold}, {31'd0, !t.done});
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({name, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({name, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    chk({name, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({name, "_mem_be"}, {28'd0, mem_be}, 32'd0);
    chk({name, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({name, "_load_done"}, {31'd0, load_done}, 32'd0);
    chk({name, "_load_err"}, {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{128'hA5_08_00_13_00_00_00_93_00_10_00_B6, 12, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{128'hA5_06_00_01_02_03_04_05_06_15, 10, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{128'hA5_06_00_01_02_03_04_05_06_16, 10, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{128'hA5_01_01, 3, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{128'hA5_00_00_00, 4, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{128'h55_FF_A5_06_00_01_02_03_04_05_06_15, 12, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{128'hA5_05_00_A5_11_22_33_44_4F, 9, 1'b1, 1'b0, 1'b1};

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

    for (int i = 0; i < 7; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

    // timeout mid-payload: partial word dropped, error after TMO idle cycles
    send(8'hA5, 0); send(8'h08, 0); send(8'h00, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    chk("tmo_hold_in_frame", {31'd0, cpu_hold}, 32'd1);
    repeat (TMO - 50) @(negedge clk);
    chk("tmo_not_early", {31'd0, load_err}, 32'd0);
    repeat (60) @(negedge clk);
    chk("tmo_err", {31'd0, load_err}, 32'd1);
    chk("tmo_done", {31'd0, load_done}, 32'd0);
    chk("tmo_hold", {31'd0, cpu_hold}, 32'd1);
    chk("tmo_pending", exp_q.size(), 0);

    // reset mid-payload: first full word written, partial second word discarded
    exp_q.push_back({8'h00, 32'h04030201, 4'b1111});
    send(8'hA5, 0); send(8'h08, 0); send(8'h00, 0);
    for (int i = 1; i <= 6; i++) send(8'(i), 0);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_pending", exp_q.size(), 0);
    run_frame(tbl[1], "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
